// File: rtl/bp_mem_block_ram.sv
// bp_mem_block_ram: block-RAM backed memory endpoint for one CCE.
// It accepts one command at a time from either the memory command stream
// (block and uncached reads) or the memory data command stream (writebacks
// and uncached writes). Each command is serviced from a synchronous block RAM
// after a programmable latency, and a response is returned that echoes the
// command header.
//
// Message layout, MSB first:
//   mem_cmd / mem_resp           : {msg_type[1:0], addr, payload}
//   mem_data_cmd / mem_data_resp : {msg_type[1:0], addr, payload, data}
module bp_mem_block_ram #(
    parameter int paddr_width_p         = 40,
    parameter int cce_block_width_p     = 512,
    parameter int dword_width_p         = 64,
    parameter int mem_els_p             = 1024,
    parameter int latency_p             = 4,
    parameter int payload_width_p       = 16,
    parameter int mem_cmd_width_p       = 2 + paddr_width_p + payload_width_p,
    parameter int mem_data_cmd_width_p  = mem_cmd_width_p + cce_block_width_p,
    parameter int mem_resp_width_p      = mem_cmd_width_p,
    parameter int mem_data_resp_width_p = mem_data_cmd_width_p
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [mem_cmd_width_p-1:0]       mem_cmd_i,
    input  logic                             mem_cmd_v_i,
    output logic                             mem_cmd_yumi_o,
    input  logic [mem_data_cmd_width_p-1:0]  mem_data_cmd_i,
    input  logic                             mem_data_cmd_v_i,
    output logic                             mem_data_cmd_yumi_o,
    output logic [mem_data_resp_width_p-1:0] mem_data_resp_o,
    output logic                             mem_data_resp_v_o,
    input  logic                             mem_data_resp_ready_i,
    output logic [mem_resp_width_p-1:0]      mem_resp_o,
    output logic                             mem_resp_v_o,
    input  logic                             mem_resp_ready_i
);

    // Message type encodings shared with the CCE side.
    localparam logic [1:0] e_cce_mem_rd    = 2'd0;
    localparam logic [1:0] e_cce_mem_uc_rd = 2'd1;
    localparam logic [1:0] e_cce_mem_wb    = 2'd2;
    localparam logic [1:0] e_cce_mem_uc_wr = 2'd3;

    localparam int offset_w_lp = $clog2(cce_block_width_p / 8);
    localparam int idx_w_lp    = $clog2(mem_els_p);
    localparam int dwords_lp   = cce_block_width_p / dword_width_p;
    localparam int dsel_w_lp   = $clog2(dwords_lp);
    localparam int cnt_w_lp    = (latency_p > 0) ? $clog2(latency_p + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Decoded command fields.
    logic [1:0]                   cmd_msg_s;
    logic [paddr_width_p-1:0]     cmd_addr_s;
    logic [payload_width_p-1:0]   cmd_payload_s;
    logic [1:0]                   dcmd_msg_s;
    logic [paddr_width_p-1:0]     dcmd_addr_s;
    logic [payload_width_p-1:0]   dcmd_payload_s;
    logic [cce_block_width_p-1:0] dcmd_data_s;
    logic                         cmd_uc_s;
    logic                         dcmd_uc_s;

    // Control state.
    state_e                       state_r;
    logic [cnt_w_lp-1:0]          cnt_r;
    logic                         is_wr_r;
    logic                         is_uc_r;
    logic [1:0]                   msg_r;
    logic [paddr_width_p-1:0]     addr_r;
    logic [payload_width_p-1:0]   payload_r;
    logic [cce_block_width_p-1:0] wdata_r;
    logic [cce_block_width_p-1:0] resp_data_r;
    logic                         data_resp_v_r;
    logic                         resp_v_r;

    // RAM and its datapath.
    logic [cce_block_width_p-1:0] mem_r [mem_els_p];
    logic [cce_block_width_p-1:0] ram_rdata_r;
    logic [idx_w_lp-1:0]          rd_idx_s;
    logic                         rd_en_s;
    logic [idx_w_lp-1:0]          wr_idx_s;
    logic                         ram_wr_en_s;
    logic [dsel_w_lp-1:0]         dsel_s;
    logic [cce_block_width_p-1:0] wr_block_s;
    logic [cce_block_width_p-1:0] rd_result_s;

    logic idle_s;
    logic take_dcmd_s;
    logic take_cmd_s;
    logic access_s;
    logic handshake_s;

    assign {cmd_msg_s, cmd_addr_s, cmd_payload_s}                = mem_cmd_i;
    assign {dcmd_msg_s, dcmd_addr_s, dcmd_payload_s, dcmd_data_s} = mem_data_cmd_i;

    // Writes take priority over reads so an eviction lands before its refill.
    assign idle_s      = (state_r == ST_IDLE);
    assign take_dcmd_s = idle_s & mem_data_cmd_v_i;
    assign take_cmd_s  = idle_s & ~mem_data_cmd_v_i & mem_cmd_v_i;

    assign mem_data_cmd_yumi_o = take_dcmd_s;
    assign mem_cmd_yumi_o      = take_cmd_s;

    // The RAM is accessed on the last WAIT cycle (counter exhausted).
    assign access_s    = (state_r == ST_WAIT) && (cnt_r == {cnt_w_lp{1'b0}});
    assign ram_wr_en_s = access_s & is_wr_r;
    assign wr_idx_s    = addr_r[offset_w_lp +: idx_w_lp];
    assign dsel_s      = addr_r[3 +: dsel_w_lp];

    assign handshake_s = (data_resp_v_r & mem_data_resp_ready_i)
                       | (resp_v_r & mem_resp_ready_i);

    assign mem_data_resp_o   = {msg_r, addr_r, payload_r, resp_data_r};
    assign mem_resp_o        = {msg_r, addr_r, payload_r};
    assign mem_data_resp_v_o = data_resp_v_r;
    assign mem_resp_v_o      = resp_v_r;

    // Classify each incoming message as block or uncached access.
    always_comb begin
        cmd_uc_s  = 1'b0;
        dcmd_uc_s = 1'b0;
        case (cmd_msg_s)
            e_cce_mem_uc_rd: cmd_uc_s = 1'b1;
            e_cce_mem_rd:    cmd_uc_s = 1'b0;
            default:         cmd_uc_s = 1'b0;
        endcase
        case (dcmd_msg_s)
            e_cce_mem_uc_wr: dcmd_uc_s = 1'b1;
            e_cce_mem_wb:    dcmd_uc_s = 1'b0;
            default:         dcmd_uc_s = 1'b0;
        endcase
    end

    // RAM read address: preload the block on accept, then keep re-reading it through WAIT.
    always_comb begin
        rd_idx_s = addr_r[offset_w_lp +: idx_w_lp];
        rd_en_s  = 1'b0;
        if (take_dcmd_s) begin
            rd_idx_s = dcmd_addr_s[offset_w_lp +: idx_w_lp];
            rd_en_s  = 1'b1;
        end else if (take_cmd_s) begin
            rd_idx_s = cmd_addr_s[offset_w_lp +: idx_w_lp];
            rd_en_s  = 1'b1;
        end else if (state_r == ST_WAIT) begin
            rd_idx_s = addr_r[offset_w_lp +: idx_w_lp];
            rd_en_s  = 1'b1;
        end else begin
            rd_idx_s = addr_r[offset_w_lp +: idx_w_lp];
            rd_en_s  = 1'b0;
        end
    end

    // Merge write data into the stored block and shape the read data.
    always_comb begin
        wr_block_s  = wdata_r;
        rd_result_s = {cce_block_width_p{1'b0}};
        if (is_uc_r) begin
            wr_block_s = ram_rdata_r;
            for (int i = 0; i < dwords_lp; i++) begin
                if (dsel_s == dsel_w_lp'(i)) begin
                    wr_block_s[i*dword_width_p +: dword_width_p]   = wdata_r[dword_width_p-1:0];
                    rd_result_s[dword_width_p-1:0]                  = ram_rdata_r[i*dword_width_p +: dword_width_p];
                end else begin
                    wr_block_s[i*dword_width_p +: dword_width_p]   = ram_rdata_r[i*dword_width_p +: dword_width_p];
                end
            end
        end else begin
            wr_block_s  = wdata_r;
            rd_result_s = ram_rdata_r;
        end
    end

    // Block RAM: one synchronous read port and one write port, contents never reset.
    always_ff @(posedge clk_i) begin
        if (ram_wr_en_s) begin
            mem_r[wr_idx_s] <= wr_block_s;
        end
        if (rd_en_s) begin
            ram_rdata_r <= mem_r[rd_idx_s];
        end
    end

    // Control FSM: accept a command, count down the latency, then hold the response until taken.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {cnt_w_lp{1'b0}};
            is_wr_r       <= 1'b0;
            is_uc_r       <= 1'b0;
            msg_r         <= 2'd0;
            addr_r        <= {paddr_width_p{1'b0}};
            payload_r     <= {payload_width_p{1'b0}};
            wdata_r       <= {cce_block_width_p{1'b0}};
            resp_data_r   <= {cce_block_width_p{1'b0}};
            data_resp_v_r <= 1'b0;
            resp_v_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_dcmd_s) begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= cnt_w_lp'(latency_p);
                        is_wr_r   <= 1'b1;
                        is_uc_r   <= dcmd_uc_s;
                        msg_r     <= dcmd_msg_s;
                        addr_r    <= dcmd_addr_s;
                        payload_r <= dcmd_payload_s;
                        wdata_r   <= dcmd_data_s;
                    end else if (take_cmd_s) begin
                        state_r   <= ST_WAIT;
                        cnt_r     <= cnt_w_lp'(latency_p);
                        is_wr_r   <= 1'b0;
                        is_uc_r   <= cmd_uc_s;
                        msg_r     <= cmd_msg_s;
                        addr_r    <= cmd_addr_s;
                        payload_r <= cmd_payload_s;
                        wdata_r   <= {cce_block_width_p{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (access_s) begin
                        state_r       <= ST_RESP;
                        resp_data_r   <= is_wr_r ? {cce_block_width_p{1'b0}} : rd_result_s;
                        data_resp_v_r <= ~is_wr_r;
                        resp_v_r      <= is_wr_r;
                    end else begin
                        cnt_r <= cnt_r - cnt_w_lp'(1);
                    end
                end
                ST_RESP: begin
                    if (handshake_s) begin
                        state_r       <= ST_IDLE;
                        data_resp_v_r <= 1'b0;
                        resp_v_r      <= 1'b0;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    data_resp_v_r <= 1'b0;
                    resp_v_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule
